// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter family.
// Helpers work on a fixed maximum width; callers zero-extend and cast back.
package rr_arb_pkg;

    localparam int ARB_MAX_N   = 64;
    localparam int ARB_IDX_MAX = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Two's-complement trick isolates the lowest set bit; result is one-hot or zero.
    function automatic logic [ARB_MAX_N-1:0] lowest_set(input logic [ARB_MAX_N-1:0] x);
        return x & (~x + {{(ARB_MAX_N-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic [ARB_IDX_MAX-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [ARB_IDX_MAX-1:0] idx;
        idx = {ARB_IDX_MAX{1'b0}};
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_MAX'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin pick: lowest requester inside the mask, else
// lowest requester overall. Winner is one-hot by construction.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int REQ_N = 4,
    parameter int IDX_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req_i,
    input  logic [REQ_N-1:0] mask_i,
    output logic [REQ_N-1:0] winner_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [REQ_N-1:0] masked_s;
    logic [REQ_N-1:0] source_s;

    // Select the masked pool when it has candidates, otherwise wrap to the full request set.
    always_comb begin
        masked_s = req_i & mask_i;
        if (|masked_s) begin
            source_s = masked_s;
        end else begin
            source_s = req_i;
        end
        winner_o = REQ_N'(lowest_set(ARB_MAX_N'(source_s)));
        idx_o    = IDX_W'(onehot_to_idx(ARB_MAX_N'(winner_o)));
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with hold timer: one holder at a time, released by
// done_i or by HOLD_MAX cycles of grant, with one idle cycle between grants.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int REQ_N    = 4,
    parameter int HOLD_MAX = 16,
    parameter int IDX_W    = $clog2(REQ_N)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [REQ_N-1:0] req_i,
    input  logic             done_i,
    output logic [REQ_N-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_val_o,
    output logic             timeout_o
);

    localparam int CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    arb_state_e       state_q, state_d;
    logic [REQ_N-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             val_q, val_d;
    logic             timeout_q, timeout_d;
    logic [REQ_N-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REQ_N-1:0] pick_winner_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             expired_s;
    logic [REQ_N-1:0] grant_shl_s;

    rr_pick #(
        .REQ_N (REQ_N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req_i),
        .mask_i   (mask_q),
        .winner_o (pick_winner_s),
        .idx_o    (pick_idx_s)
    );

    // Next-state logic: arbitrate in IDLE, count and release in BUSY.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        val_d       = val_q;
        timeout_d   = 1'b0;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        expired_s   = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
        grant_shl_s = grant_q << 1;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = pick_winner_s;
                    idx_d   = pick_idx_s;
                    val_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (done_i || expired_s) begin
                    grant_d   = {REQ_N{1'b0}};
                    val_d     = 1'b0;
                    timeout_d = expired_s && !done_i;
                    // Top-bit winner overflows the shift, leaving an empty mask (wrap to bit 0).
                    mask_d    = ~(grant_shl_s - {{(REQ_N-1){1'b0}}, 1'b1});
                    state_d   = IDLE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                grant_d = {REQ_N{1'b0}};
                val_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            grant_q   <= {REQ_N{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            val_q     <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= {REQ_N{1'b1}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign grant_val_o = val_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter (REQ_N=4, HOLD_MAX=4): a pointer-based
// reference model predicts each cycle's outputs, plus directed sequence checks.
module tb_rr_grant_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       val;
        logic       tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       srst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_val;
    logic       tmo;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];

    // reference model state
    bit         m_busy = 1'b0;
    logic [3:0] m_grant = 4'd0;
    logic [1:0] m_idx = 2'd0;
    logic       m_val = 1'b0;
    logic       m_tmo = 1'b0;
    int         m_ptr = 0;
    int         m_cnt = 0;

    rr_grant_arbiter #(.REQ_N(N), .HOLD_MAX(HOLD)) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .req_i       (req),
        .done_i      (done),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_val_o (grant_val),
        .timeout_o   (tmo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
    task automatic step(input logic s, input logic [3:0] r, input logic d);
        exp_t e;
        srst = s;
        req  = r;
        done = d;
        if (s) begin
            m_busy = 1'b0; m_grant = 4'd0; m_idx = 2'd0; m_val = 1'b0;
            m_tmo = 1'b0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            m_tmo = 1'b0;
            if (r != 4'd0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (r[i] && !m_busy) begin
                        m_busy  = 1'b1;
                        m_idx   = 2'(i);
                        m_grant = 4'd0;
                        m_grant[i] = 1'b1;
                    end
                end
                m_val = 1'b1;
                m_cnt = 0;
            end
        end else begin
            if (d || (m_cnt == HOLD - 1)) begin
                m_tmo   = !d;
                m_grant = 4'd0;
                m_val   = 1'b0;
                m_ptr   = int'(m_idx) + 1;
                m_busy  = 1'b0;
            end else begin
                m_tmo = 1'b0;
                m_cnt = m_cnt + 1;
            end
        end
        e.grant = m_grant; e.idx = m_idx; e.val = m_val; e.tmo = m_tmo;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("grant_o", 32'(grant), 32'(e.grant));
        check_eq("grant_idx_o", 32'(grant_idx), 32'(e.idx));
        check_eq("grant_val_o", 32'(grant_val), 32'(e.val));
        check_eq("timeout_o", 32'(tmo), 32'(e.tmo));
    endtask

    initial begin
        logic [3:0] seq_got[5];
        logic [3:0] seq_want[5];
        int         hold_cyc;
        int         tmo_cnt;

        seq_want[0] = 4'b0001; seq_want[1] = 4'b0010; seq_want[2] = 4'b0100;
        seq_want[3] = 4'b1000; seq_want[4] = 4'b0001;
        srst = 1'b1; req = 4'd0; done = 1'b0;
        @(negedge clk);

        // 1: reset then idle with no requests
        step(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b0, 4'b0000, 1'b0);

        // 2: all requesting, done one cycle after each grant
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 4'b1111, 1'b0);
            seq_got[g] = grant;
            step(1'b0, 4'b1111, 1'b1);
            check_eq("turnaround_gap", 32'(grant_val), 32'd0);
        end
        for (int g = 0; g < 5; g++) check_eq("rr_sequence", 32'(seq_got[g]), 32'(seq_want[g]));

        // 3: timeout on 0010, then 1000 after one idle cycle
        hold_cyc = 0; tmo_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b1010, 1'b0);
            if (grant == 4'b0010) hold_cyc++;
            if (tmo) tmo_cnt++;
        end
        check_eq("timeout_hold_cycles", 32'(hold_cyc), 32'd4);
        check_eq("timeout_pulses", 32'(tmo_cnt), 32'd1);
        step(1'b0, 4'b1010, 1'b0);
        check_eq("after_timeout_grant", 32'(grant), 32'b1000);

        // 6: winner bit 3 released, then wrap to bit 0
        step(1'b0, 4'b1001, 1'b1);
        step(1'b0, 4'b1001, 1'b0);
        check_eq("mask_wrap_grant", 32'(grant), 32'b0001);
        step(1'b0, 4'b0000, 1'b1);

        // 4: holder drops request, grant kept until timeout
        step(1'b0, 4'b0010, 1'b0);
        hold_cyc = 0;
        for (int c = 0; c < 4; c++) begin
            if (grant == 4'b0010) hold_cyc++;
            step(1'b0, 4'b0000, 1'b0);
        end
        check_eq("req_drop_hold_cycles", 32'(hold_cyc), 32'd4);
        check_eq("req_drop_timeout", 32'(tmo), 32'd1);

        // 5: done coincides with expiry, then reset mid-grant
        step(1'b0, 4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b1);
        check_eq("coincide_timeout", 32'(tmo), 32'd0);
        check_eq("coincide_release", 32'(grant_val), 32'd0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        check_eq("midgrant_reset_grant", 32'(grant), 32'd0);
        step(1'b0, 4'b1111, 1'b0);
        check_eq("post_reset_grant", 32'(grant), 32'b0001);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            check_eq("onehot_or_zero", 32'($onehot0(grant)), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
